// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants for the pipeline stall/flush controller.
//   - stage indices STG_PC..STG_WB (bit positions in the stop bus)
//   - stop bus width and per-bit Stop/NoStop values
//   - stall patterns STALL_NONE/IF/ID/EX/MEM
//   - INITIAL_PC and ZERO_WORD
//   - stall_src_e: the winning stall source, and stall_pattern() which maps it to a stop bus
package pipe_ctrl_pkg;

   localparam int unsigned STG_PC  = 0;
   localparam int unsigned STG_IF  = 1;
   localparam int unsigned STG_ID  = 2;
   localparam int unsigned STG_EX  = 3;
   localparam int unsigned STG_MEM = 4;
   localparam int unsigned STG_WB  = 5;

   localparam int unsigned STOP_BUS_W = 6;
   typedef logic [STOP_BUS_W-1:0] stop_bus_t;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   // A requester at stage k stops stages 0..k; stage k+1 bubbles itself.
   localparam stop_bus_t STALL_NONE = 6'b000000;
   localparam stop_bus_t STALL_IF   = 6'b000011;
   localparam stop_bus_t STALL_ID   = 6'b000111;
   localparam stop_bus_t STALL_EX   = 6'b001111;
   localparam stop_bus_t STALL_MEM  = 6'b011111;

   localparam logic [31:0] INITIAL_PC = 32'h0000_0000;
   localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

   typedef enum logic [2:0] {
      SRC_NONE,
      SRC_IF,
      SRC_ID,
      SRC_EX,
      SRC_MEM,
      SRC_FLUSH
   } stall_src_e;

   function automatic stop_bus_t stall_pattern(input stall_src_e src);
      stop_bus_t pat;
      pat = STALL_NONE;
      case (src)
         SRC_IF:  pat = STALL_IF;
         SRC_ID:  pat = STALL_ID;
         SRC_EX:  pat = STALL_EX;
         SRC_MEM: pat = STALL_MEM;
         default: pat = STALL_NONE;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/pipe_ctrl_mc_timer.sv
// pipe_ctrl_mc_timer: cycle timer for multi-cycle EX ops (mult/div).
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   start_i        EX starts a multi-cycle op (pulse)
//   cycles_i       op length N, sampled with start_i
//   flush_i        pipeline flush: abandons the op and suppresses done
//   busy_o         op in progress (counter non-zero)
//   done_o         registered one-cycle pulse, first cycle after the EX stall
//   ex_stall_o     EX stall request (accepted start this cycle or busy)
module pipe_ctrl_mc_timer
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MC_CNT_W = 6
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic [MC_CNT_W-1:0] cycles_i,
   input  logic                flush_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                ex_stall_o
);

   logic [MC_CNT_W-1:0] cnt_q, cnt_d;
   logic                done_q, done_d;
   logic                accept;

   assign busy_o     = (cnt_q != '0);
   assign accept     = start_i & ~busy_o & ~flush_i & ~rst_i & (cycles_i != '0);
   // The accepting cycle is itself a stall cycle, so the counter is loaded
   // with N-1 to give exactly N stalled cycles in total.
   assign ex_stall_o = accept | busy_o;
   assign done_o     = done_q;

   always_comb begin
      cnt_d  = cnt_q;
      done_d = 1'b0;
      if (flush_i) begin
         cnt_d = '0;
      end else if (accept) begin
         cnt_d  = cycles_i - MC_CNT_W'(1);
         done_d = (cycles_i == MC_CNT_W'(1));
      end else if (busy_o) begin
         cnt_d  = cnt_q - MC_CNT_W'(1);
         done_d = (cnt_q == MC_CNT_W'(1));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush controller for the 6-stage pipeline
// (pc, if, id, ex, mem, wb).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_stallreq, id_stallreq      fetch not ready / load-use hazard
//   ex_mc_start, ex_mc_cycles     multi-cycle op start and length
//   ex_mc_busy, ex_mc_done        multi-cycle op in progress / result ready pulse
//   mem_req, mem_ack              data access pending / completing
//   mem_timeout                   one-cycle pulse when the mem wait limit is hit
//   excp_valid, excp_handler_pc   exception commit and redirect target
//   stall[5:0]                    bit0 pc .. bit5 wb, 1 = stop
//   flush, new_pc                 kill in-flight stages, redirect PC
//   perf_stall_cyc, perf_flush_cnt  performance counters
// Optional: define STALL_PERF_CNT_EN to enable the performance counters;
// otherwise the perf ports are tied to zero.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MC_CNT_W    = 6,
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned MEM_CNT_W   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_stallreq,
   input  logic                  id_stallreq,
   input  logic                  ex_mc_start,
   input  logic [MC_CNT_W-1:0]   ex_mc_cycles,
   output logic                  ex_mc_busy,
   output logic                  ex_mc_done,
   input  logic                  mem_req,
   input  logic                  mem_ack,
   output logic                  mem_timeout,
   input  logic                  excp_valid,
   input  logic [31:0]           excp_handler_pc,
   output logic [STOP_BUS_W-1:0] stall,
   output logic                  flush,
   output logic [31:0]           new_pc,
   output logic [31:0]           perf_stall_cyc,
   output logic [31:0]           perf_flush_cnt
);

   localparam logic [MEM_CNT_W-1:0] WAIT_MAX = MEM_CNT_W'(MEM_TIMEOUT);

   logic       flush_w;
   logic       mem_stall_w;
   logic       ex_stall_w;
   stall_src_e src;

   // Combinational outputs are forced quiet while reset is asserted so that
   // downstream registers see no stall/flush during reset.
   assign flush_w     = ~rst & excp_valid;
   assign flush       = flush_w;
   assign new_pc      = flush_w ? excp_handler_pc : ZERO_WORD;
   assign mem_stall_w = mem_req & ~mem_ack;

   pipe_ctrl_mc_timer #(
      .MC_CNT_W(MC_CNT_W)
   ) u_mc_timer (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (ex_mc_start),
      .cycles_i   (ex_mc_cycles),
      .flush_i    (flush_w),
      .busy_o     (ex_mc_busy),
      .done_o     (ex_mc_done),
      .ex_stall_o (ex_stall_w)
   );

   always_comb begin
      src = SRC_NONE;
      if (rst)              src = SRC_NONE;
      else if (flush_w)     src = SRC_FLUSH;
      else if (mem_stall_w) src = SRC_MEM;
      else if (ex_stall_w)  src = SRC_EX;
      else if (id_stallreq) src = SRC_ID;
      else if (if_stallreq) src = SRC_IF;
   end

   assign stall = stall_pattern(src);

   // Data-memory wait tracker: counts consecutive unacked cycles, saturating.
   logic [MEM_CNT_W-1:0] mem_wait_q, mem_wait_d;
   logic                 mem_timeout_q, mem_timeout_d;

   always_comb begin
      mem_wait_d    = '0;
      mem_timeout_d = 1'b0;
      if (!flush_w && mem_stall_w) begin
         mem_wait_d    = (mem_wait_q == WAIT_MAX) ? mem_wait_q : mem_wait_q + MEM_CNT_W'(1);
         mem_timeout_d = (mem_wait_q == WAIT_MAX - MEM_CNT_W'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_wait_q    <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         mem_wait_q    <= mem_wait_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   assign mem_timeout = mem_timeout_q;

`ifdef STALL_PERF_CNT_EN
   logic [31:0] perf_stall_q, perf_flush_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (stall != STALL_NONE) perf_stall_q <= perf_stall_q + 32'd1;
         if (flush_w)             perf_flush_q <= perf_flush_q + 32'd1;
      end
   end

   assign perf_stall_cyc = perf_stall_q;
   assign perf_flush_cnt = perf_flush_q;
`else
   assign perf_stall_cyc = '0;
   assign perf_flush_cnt = '0;
`endif

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush controller for the 6-stage pipeline: pc, if, id, ex, mem, wb.
- Collects stall requests from the if, id, ex and mem stages and drives the shared stall vector consumed by every pipeline register (if_id, id_ex, ex_mem, mem_wb).
- Owns two sequencers:
  - a cycle timer for multi-cycle EX ops (mult/div);
  - a data-memory wait tracker with timeout.
- Drives pipeline flush and redirect PC on exception.

Parameters:
- MC_CNT_W, 6, width of the multi-cycle op length and counter.
- MEM_TIMEOUT, 255, consecutive unacked mem_req cycles before the timeout pulse.
- MEM_CNT_W, 8, width of the mem wait counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- if_stallreq  in  1  fetch not ready
- id_stallreq  in  1  load-use hazard
- ex_mc_start  in  1  EX starts a multi-cycle op (single-cycle pulse)
- ex_mc_cycles  in  MC_CNT_W  op length N; sampled with ex_mc_start
- ex_mc_busy  out  1  multi-cycle op in progress
- ex_mc_done  out  1  one-cycle pulse: EX result may be captured
- mem_req  in  1  MEM stage data access pending
- mem_ack  in  1  data memory completes the access this cycle
- mem_timeout  out  1  one-cycle pulse on wait-limit hit
- excp_valid  in  1  exception/eret commit from MEM
- excp_handler_pc  in  32  redirect target
- stall  out  6  bit0 pc … bit5 wb; 1 = Stop
- flush  out  1  kill all in-flight stages
- new_pc  out  32  redirect PC, valid while flush=1

Behaviour:
- Reset is synchronous and active-high (rst=1 at a clk edge). It clears mc_cnt, mem_wait_cnt, ex_mc_done and mem_timeout. Combinational outputs then evaluate to stall=0, flush=0, new_pc=0, ex_mc_busy=0.
- Reset mid-operation abandons any multi-cycle op or memory wait. No done or timeout pulse is generated afterwards.
- Stall derivation is combinational (0-cycle latency). A requester at stage k stops stages 0..k. The k+1 register inserts a bubble itself. Priority, highest first:
  - flush: 000000
  - mem_stall: 011111
  - ex_stall: 001111
  - id_stallreq: 000111
  - if_stallreq: 000011
  - otherwise 000000
- mem_stall = mem_req & ~mem_ack.
- Multi-cycle timer:
  - Start is accepted when ex_mc_start=1, ex_mc_busy=0, flush=0 and N≠0. On acceptance, mc_cnt <= N-1.
  - ex_mc_busy = (mc_cnt≠0).
  - ex_stall = accepted-start-this-cycle | ex_mc_busy. Total ex stall is exactly N cycles.
  - mc_cnt decrements once per cycle while busy. It keeps counting during mem_stall, because the divider runs independently.
  - ex_mc_done is registered. It is set on the edge where the last stall cycle ends, i.e. (busy & mc_cnt==1) or (accepted & N==1). It is high for exactly 1 cycle, the first non-ex-stalled cycle.
  - N=0: ignored (no stall, no done).
  - Start while busy: ignored.
- Mem wait tracker:
  - mem_wait_cnt increments while mem_stall and saturates at MEM_TIMEOUT.
  - It clears on mem_ack=1 or mem_req=0.
  - mem_timeout is registered: a 1-cycle pulse on the edge where the count reaches MEM_TIMEOUT.
  - Stall continues after timeout; the exception unit is expected to respond via excp_valid.
- Flush:
  - flush = excp_valid and new_pc = excp_handler_pc, both combinational. Flush overrides every stall.
  - At that edge: mc_cnt <= 0 and mem_wait_cnt <= 0. A pending ex_mc_done is suppressed, as is a mem_timeout that would have been set that edge.
  - Simultaneous ex_mc_start and excp_valid: start is rejected.
- Simultaneous mem_ack with ex_stall: mem releases and the ex pattern applies in the same cycle.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- Enabled:
  - Adds outputs perf_stall_cyc[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cyc counts cycles with stall≠0. perf_flush_cnt counts flush cycles.
  - Both wrap at 2^32, are cleared by rst and are registered.
- Disabled: ports remain and are tied to 0, so there is no counter logic and top-level wiring is unchanged.

Decomposition:
- Shared defines.v:
  - stage index constants (STG_PC..STG_WB);
  - StopBus width and Stop/NoStop values;
  - stall pattern constants STALL_NONE/IF/ID/EX/MEM;
  - InitialPc and ZeroWord.
- Sub-module mc_timer holds the multi-cycle counter, busy and done logic. It is instantiated once.

Test Plan:
- rst=1 for 2 cycles with all requests high → stall=000000, flush=0, ex_mc_busy=0, ex_mc_done=0.
- id_stallreq=1 and if_stallreq=1 together → stall=000111. Then if_stallreq only → stall=000011.
- ex_mc_start with N=4 at cycle t → stall=001111 for cycles t..t+3; ex_mc_done=1 only at t+4. With N=1, stall for 1 cycle and done at t+1. With N=0, no stall and no done.
- mem_req=1, mem_ack=0 for 3 cycles during an N=2 multi-cycle op → stall=011111 for 3 cycles; ex_mc_done still fires at t+2 while stall remains 011111.
- mem_req=1 with no ack for MEM_TIMEOUT=255 cycles → mem_timeout pulses exactly once, at cycle 255; stall stays 011111; excp_valid next cycle → stall=000000, flush=1, new_pc=excp_handler_pc.
- excp_valid=1 with excp_handler_pc=0xBFC00380 during mc_cnt=3 → stall=000000, flush=1, new_pc=0xBFC00380; next cycle ex_mc_busy=0, and no ex_mc_done occurs.
